// File: rtl/fm_display_updater_if.sv
// fm_display_updater_if
// Write bus from the FM display updater to the seven-segment display
// peripheral's register file.
//   wraddr : word address of the display register being written
//   wea    : per-byte write enables (all four set during a write)
//   wdata  : packed display word
// master : driven by the updater
// slave  : observed by the display peripheral
interface fm_display_updater_if #(
    parameter int FM_ADDR_WIDTH = 6
);
    logic [FM_ADDR_WIDTH-1:0] wraddr;
    logic [3:0]               wea;
    logic [31:0]              wdata;

    modport master (output wraddr, output wea, output wdata);
    modport slave  (input  wraddr, input  wea, input  wdata);
endinterface

// File: rtl/fm_display_updater.sv
// fm_display_updater
// Converts the tuned frequency (0.1 MHz units) and channel number into a
// packed BCD display word using a fixed-length sequential double-dabble,
// then writes it to display register 8. Requests arriving while an update
// is running collapse into a single follow-up update.
// Ports:
//   clk        : system clock
//   RSTn       : asynchronous active-low reset
//   upd_req    : level update request, sampled every rising edge
//   freq_code  : frequency, clamped to 9999 at capture
//   channel_no : channel number, clamped to 25 at capture
//   busy       : high while an update is in progress
//   upd_done   : one-cycle pulse coincident with the write strobe
//   sat        : last written word had a clamped field
//   disp       : display write bus (wraddr / wea / wdata)
module fm_display_updater #(
    parameter int FM_ADDR_WIDTH = 6,
    parameter int FREQ_WIDTH    = 14
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  upd_req,
    input  logic [FREQ_WIDTH-1:0] freq_code,
    input  logic [4:0]            channel_no,
    output logic                  busy,
    output logic                  upd_done,
    output logic                  sat,
    fm_display_updater_if.master  disp
);

    localparam int CNT_W = $clog2(FREQ_WIDTH + 1);
    localparam logic [FREQ_WIDTH-1:0] FREQ_MAX = FREQ_WIDTH'(32'd9999);
    localparam logic [4:0]            CHAN_MAX = 5'd25;
    localparam logic [FM_ADDR_WIDTH-1:0] DISP_ADDR = FM_ADDR_WIDTH'(32'd8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [15:0] dabble_adj(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Display word: channel in the low bits, then tenths..hundreds digits.
    function automatic logic [31:0] pack_word(input logic [15:0] bcd,
                                              input logic [4:0]  ch);
        return {11'd0, bcd[15:12], bcd[11:8], bcd[7:4], bcd[3:0], ch};
    endfunction

    state_t                  state_r;
    logic [FREQ_WIDTH-1:0]   bin_r;
    logic [15:0]             bcd_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [4:0]              chan_r;
    logic                    clamp_r;
    logic                    pend_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    sat_r;
    logic [3:0]              wea_r;
    logic [FM_ADDR_WIDTH-1:0] wraddr_r;
    logic [31:0]             wdata_r;

    logic [FREQ_WIDTH-1:0]   freq_clamp_s;
    logic [4:0]              chan_clamp_s;
    logic                    clamp_s;
    logic [15:0]             bcd_next_s;

    // Operand clamping and the next double-dabble accumulator value.
    always_comb begin
        freq_clamp_s = freq_code;
        chan_clamp_s = channel_no;
        clamp_s      = 1'b0;
        if (freq_code > FREQ_MAX) begin
            freq_clamp_s = FREQ_MAX;
            clamp_s      = 1'b1;
        end else begin
            freq_clamp_s = freq_code;
        end
        if (channel_no > CHAN_MAX) begin
            chan_clamp_s = CHAN_MAX;
            clamp_s      = 1'b1;
        end else begin
            chan_clamp_s = channel_no;
        end
        bcd_next_s = (dabble_adj(bcd_r) << 4'd1) | {15'd0, bin_r[FREQ_WIDTH-1]};
    end

    // Update sequencer: capture, shift steps, single write cycle.
    // The shift counter reaches zero after the last step; the following
    // edge registers the write strobe and enters WRITE.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_r  <= ST_IDLE;
            bin_r    <= '0;
            bcd_r    <= 16'd0;
            cnt_r    <= '0;
            chan_r   <= 5'd0;
            clamp_r  <= 1'b0;
            pend_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sat_r    <= 1'b0;
            wea_r    <= 4'h0;
            wraddr_r <= '0;
            wdata_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (upd_req) begin
                        bin_r   <= freq_clamp_s;
                        chan_r  <= chan_clamp_s;
                        clamp_r <= clamp_s;
                        bcd_r   <= 16'd0;
                        cnt_r   <= CNT_W'(FREQ_WIDTH);
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (upd_req) begin
                        pend_r <= 1'b1;
                    end else begin
                        pend_r <= pend_r;
                    end
                    if (cnt_r != '0) begin
                        bcd_r <= bcd_next_s;
                        bin_r <= {bin_r[FREQ_WIDTH-2:0], 1'b0};
                        cnt_r <= cnt_r - CNT_W'(1'b1);
                    end else begin
                        wea_r    <= 4'hf;
                        wraddr_r <= DISP_ADDR;
                        wdata_r  <= pack_word(bcd_r, chan_r);
                        done_r   <= 1'b1;
                        sat_r    <= clamp_r;
                        state_r  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wea_r    <= 4'h0;
                    wraddr_r <= '0;
                    done_r   <= 1'b0;
                    // A request sampled on this very edge is serviced at once.
                    if (pend_r || upd_req) begin
                        pend_r  <= 1'b0;
                        bin_r   <= freq_clamp_s;
                        chan_r  <= chan_clamp_s;
                        clamp_r <= clamp_s;
                        bcd_r   <= 16'd0;
                        cnt_r   <= CNT_W'(FREQ_WIDTH);
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    pend_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    wea_r    <= 4'h0;
                    wraddr_r <= '0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign upd_done    = done_r;
    assign sat         = sat_r;
    assign disp.wraddr = wraddr_r;
    assign disp.wea    = wea_r;
    assign disp.wdata  = wdata_r;

endmodule

// File: tb/tb_fm_display_updater.sv
// tb_fm_display_updater
// Directed self-checking bench for fm_display_updater: reset state, basic
// conversion and latency, clamping, request coalescing, reset mid-update,
// held request and boundary frequencies.
module tb_fm_display_updater;

    logic        clk;
    logic        RSTn;
    logic        upd_req;
    logic [13:0] freq_code;
    logic [4:0]  channel_no;
    logic        busy;
    logic        upd_done;
    logic        sat;

    fm_display_updater_if #(.FM_ADDR_WIDTH(6)) disp_if ();

    fm_display_updater #(.FM_ADDR_WIDTH(6), .FREQ_WIDTH(14)) dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .upd_req    (upd_req),
        .freq_code  (freq_code),
        .channel_no (channel_no),
        .busy       (busy),
        .upd_done   (upd_done),
        .sat        (sat),
        .disp       (disp_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int busy_low = 0;
    bit busy_watch = 1'b0;
    logic [31:0] wq[$];
    int          cq[$];

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter, read on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] digits_ok(input logic [31:0] w);
        logic [31:0] ok;
        ok = 32'd1;
        for (int i = 0; i < 4; i++) begin
            if (w[5 + 4*i +: 4] > 4'd9) ok = 32'd0;
        end
        return ok;
    endfunction

    // Write-bus monitor: strobe coherence and a record of every write.
    always @(negedge clk) begin
        if (RSTn) begin
            check_val("done_vs_wea", 32'(upd_done), 32'(disp_if.wea == 4'hf));
            if (disp_if.wea == 4'hf) begin
                check_val("wraddr", 32'(disp_if.wraddr), 32'd8);
                check_val("nibble_le9", digits_ok(disp_if.wdata), 32'd1);
                wr_cnt++;
                wq.push_back(disp_if.wdata);
                cq.push_back(cyc);
            end
            if (busy_watch && !busy) busy_low++;
        end
    end

    // Pulse upd_req for one cycle; cap is the edge count after the capture edge.
    task automatic pulse_req(output int cap);
        @(negedge clk);
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        cap = cyc;
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n;
        n = 0;
        while (wr_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (wr_cnt < target) check_val("write_timeout", 32'(wr_cnt), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},   32'(busy), 32'd0);
        check_val({tag, "_done"},   32'(upd_done), 32'd0);
        check_val({tag, "_sat"},    32'(sat), 32'd0);
        check_val({tag, "_wea"},    32'(disp_if.wea), 32'd0);
        check_val({tag, "_wraddr"}, 32'(disp_if.wraddr), 32'd0);
        check_val({tag, "_wdata"},  disp_if.wdata, 32'd0);
    endtask

    // One isolated update with latency, data and sat checks.
    task automatic single_update(input string tag, input logic [13:0] f, input logic [4:0] ch,
                                 input logic [31:0] exp_w, input logic [31:0] exp_sat);
        int cap;
        int b;
        b = wq.size();
        freq_code  = f;
        channel_no = ch;
        pulse_req(cap);
        wait_writes(b + 1, 40);
        if (wq.size() > b) begin
            check_val({tag, "_lat"},   32'(cq[b]), 32'(cap + 15));
            check_val({tag, "_wdata"}, wq[b], exp_w);
        end
        check_val({tag, "_sat"}, 32'(sat), exp_sat);
        repeat (4) @(negedge clk);
        #1;
        check_val({tag, "_count"}, 32'(wq.size()), 32'(b + 1));
        check_val({tag, "_idle"},  32'(busy), 32'd0);
    endtask

    initial begin
        int cap;
        int b;
        int base;
        RSTn       = 1'b0;
        upd_req    = 1'b0;
        freq_code  = 14'd0;
        channel_no = 5'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        RSTn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic update, with operands changed right after capture.
        b = wq.size();
        freq_code  = 14'd1011;
        channel_no = 5'd7;
        pulse_req(cap);
        check_val("basic_busy_rise", 32'(busy), 32'd1);
        freq_code  = 14'd5555;
        channel_no = 5'd20;
        wait_writes(b + 1, 40);
        if (wq.size() > b) begin
            check_val("basic_lat",   32'(cq[b]), 32'(cap + 15));
            check_val("basic_wdata", wq[b], 32'h0002_0227);
        end
        check_val("basic_sat", 32'(sat), 32'd0);
        check_val("basic_busy_in_write", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("basic_wea_off", 32'(disp_if.wea), 32'd0);
        check_val("basic_wdata_hold", disp_if.wdata, 32'h0002_0227);
        repeat (3) @(negedge clk);
        check_val("basic_count", 32'(wq.size()), 32'(b + 1));

        // Clamping, then back to an in-range update.
        single_update("clamp", 14'd12000, 5'd31, 32'h0013_3339, 32'd1);
        single_update("valid", 14'd875,   5'd0,  32'h0001_0EA0, 32'd0);

        // Coalescing: three extra pulses during SHIFT, frequency changes before write.
        b = wq.size();
        base = wr_cnt;
        freq_code  = 14'd1011;
        channel_no = 5'd3;
        busy_low   = 0;
        pulse_req(cap);
        busy_watch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            upd_req = 1'b1;
            @(negedge clk);
            upd_req = 1'b0;
        end
        freq_code = 14'd1080;
        wait_writes(base + 2, 60);
        busy_watch = 1'b0;
        check_val("coal_busy_low", 32'(busy_low), 32'd0);
        if (wq.size() >= b + 2) begin
            check_val("coal_w1",   wq[b], 32'h0002_0223);
            check_val("coal_w2",   wq[b+1], 32'h0002_1003);
            check_val("coal_lat1", 32'(cq[b]), 32'(cap + 15));
            check_val("coal_lat2", 32'(cq[b+1]), 32'(cap + 31));
        end
        repeat (25) @(negedge clk);
        check_val("coal_count", 32'(wr_cnt), 32'(base + 2));

        // Reset five cycles after capture, with a pending request outstanding.
        base = wr_cnt;
        freq_code  = 14'd2222;
        channel_no = 5'd1;
        pulse_req(cap);
        @(negedge clk);
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        repeat (3) @(negedge clk);
        RSTn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        RSTn = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check_val("midrst_nowrite", 32'(wr_cnt), 32'(base));
        single_update("after_rst", 14'd9999, 5'd12, 32'h0013_332C, 32'd0);

        // Boundary: zero frequency.
        single_update("zero", 14'd0, 5'd0, 32'h0000_0000, 32'd0);

        // Held request for 40 cycles: four back-to-back updates.
        b = wq.size();
        base = wr_cnt;
        freq_code  = 14'd1234;
        channel_no = 5'd5;
        busy_low   = 0;
        @(negedge clk);
        upd_req = 1'b1;
        @(negedge clk);
        cap = cyc;
        busy_watch = 1'b1;
        repeat (39) @(negedge clk);
        upd_req = 1'b0;
        wait_writes(base + 4, 100);
        busy_watch = 1'b0;
        check_val("held_busy_low", 32'(busy_low), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (wq.size() > b + i) begin
                check_val("held_lat",   32'(cq[b+i]), 32'(cap + 15 + 16*i));
                check_val("held_wdata", wq[b+i], 32'h0002_4685);
            end
        end
        repeat (20) @(negedge clk);
        #1;
        check_val("held_count", 32'(wr_cnt), 32'(base + 4));
        check_val("held_idle",  32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
